hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers. It detects load-use and branch-operand hazards in ID, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It also flushes IF on taken branches and jumps, and raises a sticky error when a memory access exceeds a timeout. Register 0 never creates a hazard. Optional counters record stall and flush cycles.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_if.sv | 51 +++++
 rtl/hazard_match.sv | 15 +
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_t;

    localparam int REG_ZERO = 0;

    localparam int HZ_REG_AW  = 5;
    localparam int HZ_TMO_W   = 8;
    localparam int HZ_TMO_CYC = 200;
    localparam int HZ_CNT_W   = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decode/stage inputs and hold/flush controls.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW
);
    logic              id_ex_memread;
    logic              id_ex_regwrite;
    logic [REG_AW-1:0] id_ex_wreg;
    logic              ex_mem_memread;
    logic              ex_mem_memwrite;
    logic [REG_AW-1:0] ex_mem_wreg;
    logic [REG_AW-1:0] if_id_rs;
    logic [REG_AW-1:0] if_id_rt;
    logic              if_id_use_rt;
    logic              jump;
    logic              beq;
    logic              bne;
    logic              if_equal;
    logic              dmem_ready;

    logic              pc_hold;
    logic              if_id_hold;
    logic              id_ex_flush;
    logic              if_flush;
    logic              id_ex_hold;
    logic              ex_mem_hold;
    logic              mem_wait;
    logic              mem_err;

    // pipeline side
    modport master (
        output id_ex_memread, id_ex_regwrite, id_ex_wreg,
               ex_mem_memread, ex_mem_memwrite, ex_mem_wreg,
               if_id_rs, if_id_rt, if_id_use_rt,
               jump, beq, bne, if_equal, dmem_ready,
        input  pc_hold, if_id_hold, id_ex_flush, if_flush,
               id_ex_hold, ex_mem_hold, mem_wait, mem_err
    );

    // controller side
    modport slave (
        input  id_ex_memread, id_ex_regwrite, id_ex_wreg,
               ex_mem_memread, ex_mem_memwrite, ex_mem_wreg,
               if_id_rs, if_id_rt, if_id_use_rt,
               jump, beq, bne, if_equal, dmem_ready,
        output pc_hold, if_id_hold, id_ex_flush, if_flush,
               id_ex_hold, ex_mem_hold, mem_wait, mem_err
    );

endinterface

// File: rtl/hazard_match.sv
// One source-vs-destination register comparison; register 0 never matches.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] dst,
    input  logic              src_used,
    output logic              hit
);

    assign hit = src_used && (src == dst) && (src != REG_AW'(REG_ZERO));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use/branch stalls, IF flush, memory-wait freeze and timeout.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = HZ_REG_AW,
    parameter int TMO_W   = HZ_TMO_W,
    parameter int TMO_CYC = HZ_TMO_CYC,
    parameter int CNT_W   = HZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (TMO_CYC < 1 || TMO_CYC >= (2 ** TMO_W) || CNT_W < 1) begin : g_bad_cfg
        $error("hazard_ctrl: TMO_CYC must be 1..2^TMO_W-1 and CNT_W >= 1");
    end

    hz_state_t               state;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [TMO_W-1:0]        tmo_inc;
    logic                    err_q;

    // index 0: rs/EX, 1: rt/EX, 2: rs/MEM, 3: rt/MEM
    logic [3:0][REG_AW-1:0]  src_v;
    logic [3:0][REG_AW-1:0]  dst_v;
    logic [3:0]              use_v;
    logic [3:0]              hit;

    logic ex_hit, mem_hit, br, hz, taken, memacc, frz;
    logic pc_hold_w, if_flush_w;

    assign src_v = {bus.if_id_rt, bus.if_id_rs, bus.if_id_rt, bus.if_id_rs};
    assign dst_v = {bus.ex_mem_wreg, bus.ex_mem_wreg, bus.id_ex_wreg, bus.id_ex_wreg};
    assign use_v = {bus.if_id_use_rt, 1'b1, bus.if_id_use_rt, 1'b1};

    for (genvar i = 0; i < 4; i++) begin : g_match
        hazard_match #(.REG_AW(REG_AW)) u_match (
            .src      (src_v[i]),
            .dst      (dst_v[i]),
            .src_used (use_v[i]),
            .hit      (hit[i])
        );
    end

    always_comb begin
        ex_hit  = hit[0] | hit[1];
        mem_hit = hit[2] | hit[3];
        br      = bus.beq | bus.bne;
        hz      = (bus.id_ex_memread & ex_hit)
                | (br & bus.id_ex_regwrite & ex_hit)
                | (br & bus.ex_mem_memread & mem_hit);
        taken   = bus.jump | (bus.beq & bus.if_equal) | (bus.bne & ~bus.if_equal);
        memacc  = bus.ex_mem_memread | bus.ex_mem_memwrite;
        // freeze starts in the same cycle as the unready access, no bubble
        frz     = ((state == HZ_RUN) & memacc & ~bus.dmem_ready)
                | ((state == HZ_WAIT) & ~bus.dmem_ready);
    end

    assign pc_hold_w       = frz | hz;
    assign if_flush_w      = ~frz & ~hz & taken;
    assign bus.pc_hold     = pc_hold_w;
    assign bus.if_id_hold  = pc_hold_w;
    assign bus.id_ex_flush = ~frz & hz;
    assign bus.if_flush    = if_flush_w;
    assign bus.id_ex_hold  = frz;
    assign bus.ex_mem_hold = frz;
    assign bus.mem_wait    = (state == HZ_WAIT);
    assign bus.mem_err     = err_q;

    assign tmo_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= HZ_RUN;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                HZ_RUN: begin
                    if (memacc && !bus.dmem_ready) begin
                        state   <= HZ_WAIT;
                        tmo_cnt <= TMO_W'(1);
                        if (TMO_W'(1) >= TMO_W'(TMO_CYC)) err_q <= 1'b1;
                    end
                end
                HZ_WAIT: begin
                    if (bus.dmem_ready) begin
                        state <= HZ_RUN;
                    end else begin
                        tmo_cnt <= tmo_inc;
                        if (tmo_inc >= TMO_W'(TMO_CYC)) err_q <= 1'b1;
                    end
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold_w)  stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_flush_w) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle freeze/timeout sequences.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    hazard_ctrl #(.REG_AW(5), .TMO_W(8), .TMO_CYC(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    hazard_ctrl #(.REG_AW(5), .TMO_W(8), .TMO_CYC(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct packed {
        logic       ex_rd, ex_wr;
        logic [4:0] ex_dst;
        logic       mem_rd, mem_wr;
        logic [4:0] mem_dst;
        logic [4:0] rs, rt;
        logic       use_rt, jump, beq, bne, eq, rdy;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] e;
        string      nm;
    } vec_t;

    // expected bit order: pc_hold if_id_hold id_ex_flush if_flush id_ex_hold ex_mem_hold mem_wait mem_err
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_HZ   = 8'b1110_0000;
    localparam logic [7:0] E_FL   = 8'b0001_0000;
    localparam logic [7:0] E_FRZ0 = 8'b1100_1100;
    localparam logic [7:0] E_FRZW = 8'b1100_1110;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    string      nm_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;

    function automatic stim_t st(logic ex_rd, logic ex_wr, logic [4:0] ex_dst,
                                 logic mem_rd, logic mem_wr, logic [4:0] mem_dst,
                                 logic [4:0] rs, logic [4:0] rt, logic use_rt,
                                 logic jump, logic beq, logic bne, logic eq, logic rdy);
        stim_t s;
        s = '{ex_rd, ex_wr, ex_dst, mem_rd, mem_wr, mem_dst, rs, rt, use_rt,
              jump, beq, bne, eq, rdy};
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic drive(input stim_t s);
        bus.id_ex_memread   = s.ex_rd;
        bus.id_ex_regwrite  = s.ex_wr;
        bus.id_ex_wreg      = s.ex_dst;
        bus.ex_mem_memread  = s.mem_rd;
        bus.ex_mem_memwrite = s.mem_wr;
        bus.ex_mem_wreg     = s.mem_dst;
        bus.if_id_rs        = s.rs;
        bus.if_id_rt        = s.rt;
        bus.if_id_use_rt    = s.use_rt;
        bus.jump            = s.jump;
        bus.beq             = s.beq;
        bus.bne             = s.bne;
        bus.if_equal        = s.eq;
        bus.dmem_ready      = s.rdy;
    endtask

    task automatic check();
        logic [7:0] e, a;
        string      nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        a  = {bus.pc_hold, bus.if_id_hold, bus.id_ex_flush, bus.if_flush,
              bus.id_ex_hold, bus.ex_mem_hold, bus.mem_wait, bus.mem_err};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b", nm, a, e);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (stall_cnt !== 32'(exp_stall)) begin
            n_bad++;
            $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, exp_stall);
        end
        n_cmp++;
        if (flush_cnt !== 32'(exp_flush)) begin
            n_bad++;
            $display("FAIL %s flush_cnt: got %0d want %0d", nm, flush_cnt, exp_flush);
        end
`endif
        if (rst_n) begin
            if (e[7]) exp_stall++;
            if (e[4]) exp_flush++;
        end
    endtask

    task automatic apply(input stim_t s, input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        drive(s);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        check();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(idle());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic add(input stim_t s, input logic [7:0] e, input string nm);
        vec_t v;
        v.s = s; v.e = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        //    ex_rd ex_wr dst mem_rd mem_wr dst  rs    rt  use jmp beq bne eq rdy
        add(st(0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1), E_NONE, "idle");
        add(st(1, 1, 5'd8, 0, 0, 5'd0, 5'd8, 5'd3, 1, 0, 0, 0, 0, 1), E_HZ,   "loaduse_rs");
        add(st(1, 1, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1), E_NONE, "loaduse_r0");
        add(st(1, 1, 5'd8, 0, 0, 5'd0, 5'd2, 5'd8, 0, 0, 0, 0, 0, 1), E_NONE, "rt_unused");
        add(st(1, 1, 5'd8, 0, 0, 5'd0, 5'd2, 5'd8, 1, 0, 0, 0, 0, 1), E_HZ,   "loaduse_rt");
        add(st(0, 1, 5'd9, 0, 0, 5'd0, 5'd9, 5'd0, 0, 0, 1, 0, 1, 1), E_HZ,   "beq_ex_dep");
        add(st(0, 1, 5'd4, 0, 0, 5'd0, 5'd9, 5'd0, 0, 0, 1, 0, 1, 1), E_FL,   "beq_taken");
        add(st(0, 0, 5'd0, 0, 0, 5'd0, 5'd9, 5'd0, 0, 0, 0, 1, 1, 1), E_NONE, "bne_not_taken");
        add(st(0, 0, 5'd0, 0, 0, 5'd0, 5'd9, 5'd0, 0, 0, 0, 1, 0, 1), E_FL,   "bne_taken");
        add(st(0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 1), E_FL,   "jump");
        add(st(0, 0, 5'd0, 1, 0, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0, 0, 1), E_HZ,   "beq_mem_load");
        add(st(0, 1, 5'd9, 0, 0, 5'd0, 5'd9, 5'd0, 0, 0, 0, 0, 0, 1), E_NONE, "alu_dep_fwd");
        add(st(0, 0, 5'd0, 1, 0, 5'd6, 5'd6, 5'd6, 1, 0, 0, 0, 0, 1), E_NONE, "mem_load_fwd");
        add(st(1, 1, 5'd7, 0, 0, 5'd0, 5'd7, 5'd0, 0, 1, 0, 0, 0, 1), E_HZ,   "jump_vs_hz");
        add(st(0, 0, 5'd0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 1), E_FL,   "store_ready");
        add(st(0, 1, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1), E_FL,   "beq_r0_taken");

        drive(idle());
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(idle(), E_NONE, "reset_state");

        foreach (tbl[i]) apply(tbl[i].s, tbl[i].e, tbl[i].nm);

        // load-use stalls exactly one cycle
        apply(st(1, 1, 5'd8, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 0, 0, 1), E_HZ,   "lu_c1");
        apply(st(0, 0, 5'd0, 1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0, 1), E_NONE, "lu_c2");

        // stalled branch re-evaluated next cycle
        apply(st(0, 1, 5'd9, 0, 0, 5'd0, 5'd9, 5'd0, 0, 0, 1, 0, 1, 1), E_HZ,   "br_c1");
        apply(st(0, 0, 5'd0, 0, 0, 5'd9, 5'd9, 5'd0, 0, 0, 1, 0, 1, 1), E_FL,   "br_c2");

        // three-cycle memory wait
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), E_FRZ0, "mw_c1");
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), E_FRZW, "mw_c2");
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), E_FRZW, "mw_c3");
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1), 8'b0000_0010, "mw_done");
        apply(idle(), E_NONE, "mw_run");

        // jump held off by freeze, flushes once released
        apply(st(0, 0, 5'd0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0), E_FRZ0, "jf_c1");
        apply(st(0, 0, 5'd0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 1), 8'b0001_0010, "jf_c2");
        apply(idle(), E_NONE, "jf_run");

        // timeout after TMO wait cycles, sticky until reset
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), E_FRZ0, "to_c0");
        for (int k = 1; k < TMO; k++)
            apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), E_FRZW,
                  $sformatf("to_c%0d", k));
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), 8'b1100_1111, "to_err");
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1), 8'b0000_0011, "to_ready");
        apply(idle(), 8'b0000_0001, "to_sticky");
        apply(st(0, 0, 5'd0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0), 8'b1100_1101, "to_rewait");
        do_reset();
        apply(idle(), E_NONE, "to_cleared");
        apply(st(1, 1, 5'd8, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 0, 0, 1), E_HZ, "post_reset_hz");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
